// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO read-side word packer.
package fifo_pkg;
  localparam int DATA_W      = 8;                  // FIFO byte width
  localparam int LANES       = 4;                  // bytes per output word
  localparam int OUT_W       = DATA_W * LANES;     // packed word width
  localparam int LANE_W      = $clog2(LANES + 1);  // counts 0..LANES inclusive
  localparam int TIMEOUT_DEF = 16;                 // idle cycles before a partial flush

  typedef enum logic {
    ACC  = 1'b0,   // popping and capturing bytes for the current word
    HOLD = 1'b1    // word complete, output still occupied
  } pack_state_e;
endpackage

// File: rtl/pack_out_reg.sv
// Valid/ready output holding register: owns out_valid, out_data, out_be.
// A load is only requested when the register is free or being drained on the
// same edge, so the payload never changes under a stalled valid.
module pack_out_reg #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [DATA_W*LANES-1:0]  data_i,
  input  logic [LANES-1:0]         be_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [DATA_W*LANES-1:0]  data_o,
  output logic [LANES-1:0]         be_o
);
  logic                    valid_q;
  logic [DATA_W*LANES-1:0] data_q;
  logic [LANES-1:0]        be_q;

  // load wins over drain so back-to-back words keep valid high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      be_q    <= be_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign be_o    = be_q;
endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async FIFO: pops bytes and packs LANES of them
// into one word presented on a valid/ready port. Byte 0 lands in the LSBs.
// Optional build macro PACK_TIMEOUT_EN flushes a partial word after TIMEOUT
// idle cycles on an empty FIFO, with out_be marking only the filled lanes.
module fifo_rd_packer import fifo_pkg::*;
`ifdef PACK_TIMEOUT_EN
  #(parameter int TIMEOUT = TIMEOUT_DEF)
`endif
(
  input  logic              rclk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [LANES-1:0]  out_be
);
  localparam logic [LANE_W-1:0] LANES_C = LANE_W'(LANES);

  pack_state_e                  state_q, state_d;
  logic [LANE_W-1:0]            issued_q, issued_d;
  logic [LANE_W-1:0]            got_q, got_d, got_cap;
  logic [LANES-1:0][DATA_W-1:0] lanes_q, lanes_d, lanes_cap;
  logic                         cap_q;      // a popped byte is on fifo_dout this cycle
  logic                         load;
  logic                         flush;
  logic [LANES-1:0]             load_be;

  // pop only from a non-empty FIFO, while the current word still needs bytes
  assign fifo_rd_en = rst && !fifo_empty && (issued_q < LANES_C) && (state_q == ACC);

  // merge this cycle's returning byte into lane[got]
  always_comb begin
    lanes_cap = lanes_q;
    got_cap   = got_q;
    if (cap_q) begin
      for (int i = 0; i < LANES; i++)
        if (got_q == LANE_W'(i)) lanes_cap[i] = fifo_dout;
      got_cap = got_q + 1'b1;
    end
  end

`ifdef PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          idle;

  // idle timer: partial word, nothing in flight, FIFO empty
  always_comb begin
    idle   = (state_q == ACC) && (got_q != '0) && (got_q < LANES_C) &&
             (issued_q == got_q) && fifo_empty;
    flush  = idle && (idle_q == TW'(TIMEOUT - 1));
    idle_d = (idle && !flush) ? idle_q + 1'b1 : '0;
  end

  // idle timer register
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else      idle_q <= idle_d;
  end

  // only lanes [got-1:0] carry data in the loaded word
  always_comb begin
    load_be = '0;
    for (int i = 0; i < LANES; i++)
      if (LANE_W'(i) < got_cap) load_be[i] = 1'b1;
  end
`else
  assign flush   = 1'b0;
  assign load_be = '1;
`endif

  // next state: pop accounting, word completion and hand-off to the output
  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    got_d    = got_cap;
    lanes_d  = lanes_cap;
    load     = 1'b0;
    if (fifo_rd_en) issued_d = issued_q + 1'b1;
    case (state_q)
      ACC: begin
        if ((cap_q && (got_cap == LANES_C)) || flush) begin
          if (!out_valid || out_ready) load = 1'b1;
          else                         state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          load    = 1'b1;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    // a loaded word leaves clean lanes so a short word never carries stale bytes
    if (load) begin
      issued_d = '0;
      got_d    = '0;
      lanes_d  = '0;
    end
  end

  // state, counters and lane storage; reset discards any partial word
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state_q  <= ACC;
      issued_q <= '0;
      got_q    <= '0;
      lanes_q  <= '0;
      cap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      got_q    <= got_d;
      lanes_q  <= lanes_d;
      cap_q    <= fifo_rd_en;
    end
  end

  pack_out_reg #(.DATA_W(DATA_W), .LANES(LANES)) u_out (
    .clk_i   (rclk),
    .rst_ni  (rst),
    .load_i  (load),
    .data_i  (lanes_cap),
    .be_i    (load_be),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .be_o    (out_be)
  );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO byte model, scoreboard of expected words,
// and a monitor that checks each accepted word and the handshake rules.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [LANES-1:0] be;
  } word_t;

  logic              rclk = 1'b0;
  logic              rst = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic [LANES-1:0]  out_be;

  int checks = 0;
  int errors = 0;
  int empty_mode = 0;   // 0 real, 1 toggle, 2 random, 3 forced empty
  int ready_mode = 2;   // 0 always, 1 random, 2 never

  logic [DATA_W-1:0] fq[$];     // FIFO contents
  logic [DATA_W-1:0] pend[$];   // bytes of the word being assembled in the model
  word_t             exp_q[$];  // expected words in order

  fifo_rd_packer dut (
    .rclk       (rclk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_be     (out_be)
  );

  initial forever #5 rclk = ~rclk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: every LANES bytes fed in become one full word
  task automatic push_byte(input logic [DATA_W-1:0] b);
    word_t w;
    fq.push_back(b);
    pend.push_back(b);
    if (pend.size() == LANES) begin
      w.data = '0;
      for (int i = 0; i < LANES; i++) w.data[i*DATA_W +: DATA_W] = pend[i];
      w.be = '1;
      exp_q.push_back(w);
      pend.delete();
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge rclk);
      n++;
    end
    repeat (2) @(negedge rclk);
    chk(name, exp_q.size(), 0);
  endtask

  // asynchronous reset mid-cycle; model drops everything in flight
  task automatic pulse_reset();
    @(posedge rclk);
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_be", out_be, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    fq.delete();
    pend.delete();
    exp_q.delete();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rst = 1'b1;
  endtask

  // FIFO read port: data appears the cycle after a pop
  always @(posedge rclk)
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();

  // FIFO empty flag
  initial begin
    bit tog;
    tog = 1'b0;
    forever begin
      @(posedge rclk);
      #2;
      tog = ~tog;
      case (empty_mode)
        1:       fifo_empty = tog || (fq.size() == 0);
        2:       fifo_empty = ($urandom_range(3) == 0) || (fq.size() == 0);
        3:       fifo_empty = 1'b1;
        default: fifo_empty = (fq.size() == 0);
      endcase
    end
  end

  // downstream ready
  initial forever begin
    @(posedge rclk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
  end

  // monitor: scoreboard compare on accept, stall stability, no pop on empty
  initial begin
    logic             pv, pr;
    logic [OUT_W-1:0] pd;
    logic [LANES-1:0] pb;
    word_t            w;
    pv = 1'b0; pr = 1'b0; pd = '0; pb = '0;
    forever begin
      @(negedge rclk);
      if (!rst) begin
        pv = 1'b0;
      end else begin
        if (fifo_rd_en) chk("rd_en_while_empty", fifo_empty, 0);
        if (pv && !pr) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, pd);
          chk("stall_be", out_be, pb);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", exp_q.size(), 1);
          end else begin
            w = exp_q.pop_front();
            chk("word_data", out_data, w.data);
            chk("word_be", out_be, w.be);
          end
        end
        pv = out_valid; pr = out_ready; pd = out_data; pb = out_be;
      end
    end
  end

  initial begin
    int    t_rd0, t_rdn, t_v, pops, nv, nrd;
    word_t w;

    // reset state
    repeat (3) @(negedge rclk);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_be", out_be, 0);
    chk("reset_rd_en", fifo_rd_en, 0);

    // preloaded 01..08, always ready: latency and one-cycle pop gap
    ready_mode = 0;
    empty_mode = 0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    rst = 1'b1;
    t_rd0 = -1; t_rdn = -1; t_v = -1; pops = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge rclk);
      if (fifo_rd_en) begin
        if (t_rd0 < 0) t_rd0 = c;
        t_rdn = c;
        pops++;
      end
      if (out_valid && t_v < 0) t_v = c;
    end
    chk("first_latency", t_v - t_rd0, LANES + 1);
    chk("pop_span", t_rdn - t_rd0, 2 * LANES);
    chk("pop_count", pops, 2 * LANES);
    wait_drain("t1_drain", 50);

    // FIFO empty throughout
    empty_mode = 3;
    nv = 0; nrd = 0;
    repeat (30) begin
      @(negedge rclk);
      if (out_valid) nv++;
      if (fifo_rd_en) nrd++;
    end
    chk("empty_no_pop", nrd, 0);
    chk("empty_no_valid", nv, 0);

    // 12 bytes, downstream stalled: first word held, second parked in HOLD
    empty_mode = 0;
    ready_mode = 2;
    for (int i = 1; i <= 12; i++) push_byte(8'(i));
    repeat (30) @(negedge rclk);
    chk("hold_rd_en", fifo_rd_en, 0);
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, 32'h04030201);
    chk("hold_fifo_left", fq.size(), 4);
    ready_mode = 0;
    nv = 0;
    do begin
      @(negedge rclk);
      nv++;
    end while (!out_ready && nv < 10);
    @(negedge rclk);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, 32'h08070605);
    wait_drain("t3_drain", 60);

    // two bytes then empty
    ready_mode = 0;
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
`ifdef PACK_TIMEOUT_EN
    w.data = 32'h0000BBAA;
    w.be   = 4'h3;
    exp_q.push_back(w);
`endif
    nv = 0;
    repeat (100) begin
      @(negedge rclk);
      if (out_valid) nv++;
    end
`ifdef PACK_TIMEOUT_EN
    chk("partial_flush_cycles", nv, 1);
    chk("partial_flush_seen", exp_q.size(), 0);
`else
    chk("partial_held", nv, 0);
`endif
    pulse_reset();

    // reset with a word held and three bytes of the next captured
    ready_mode = 2;
    for (int i = 0; i < 7; i++) fq.push_back(8'(8'h11 + i));
    repeat (12) @(negedge rclk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, 32'h14131211);
    pulse_reset();
    ready_mode = 0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h21 + i));
    wait_drain("post_rst_word", 40);

    // empty toggling every other cycle
    empty_mode = 1;
    for (int i = 0; i < 12; i++) push_byte(8'($urandom));
    wait_drain("toggle_drain", 200);

    // random empty and random ready
    empty_mode = 2;
    ready_mode = 1;
    for (int i = 0; i < 40 * LANES; i++) push_byte(8'($urandom));
    wait_drain("random_drain", 4000);
    chk("fifo_consumed", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
